// File: rtl/eth_rx_frame_filter.sv
// rtl/eth_rx_frame_filter.sv - store-and-forward RX frame filter with drop/good statistics
module eth_rx_frame_filter #(
    parameter int P_DEPTH      = 512,
    parameter int P_MIN_LENGTH = 64,
    parameter int P_MAX_LENGTH = 9600,
    parameter int P_FRM_DEPTH  = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_stat_rx_status,
    input  logic                           s_axis_tvalid,
    input  logic [63:0]                    s_axis_tdata,
    input  logic [7:0]                     s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [63:0]                    m_axis_tdata,
    output logic [7:0]                     m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [31:0]                    o_good_cnt,
    output logic [31:0]                    o_drop_cnt,
    output logic [$clog2(P_FRM_DEPTH):0]   o_frm_pending
);
    localparam int AW = $clog2(P_DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(P_FRM_DEPTH) + 1;
    localparam logic [13:0] MIN_LEN = 14'(P_MIN_LENGTH);
    localparam logic [13:0] MAX_LEN = 14'(P_MAX_LENGTH);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} wr_state_t;

    wr_state_t   state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt, wr_cmt, wr_cmt_nxt, rd_ptr, used;
    logic [13:0] byte_cnt, byte_nxt, bytes_acc;
    logic [14:0] byte_sum;
    logic [3:0]  kept;
    logic        full, frm_full, len_ok, wr_en, commit, drop;

    logic [72:0] mem [P_DEPTH];
    logic [72:0] ram_q;
    logic        rd_en, rd_vld, out_free, pop;

    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == PW'(P_DEPTH));
    assign frm_full = (o_frm_pending == FW'(P_FRM_DEPTH));

    always_comb begin
        kept = '0;
        for (int i = 0; i < 8; i++) begin
            kept = kept + {3'b000, s_axis_tkeep[i]};
        end
    end

    // First beat of a frame loads the count, later beats accumulate with saturation
    assign byte_sum  = ((state == S_IDLE) ? 15'd0 : {1'b0, byte_cnt}) + {11'd0, kept};
    assign bytes_acc = byte_sum[14] ? 14'h3FFF : byte_sum[13:0];
    assign len_ok    = (bytes_acc >= MIN_LEN) && (bytes_acc <= MAX_LEN);

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_cmt_nxt = wr_cmt;
        byte_nxt   = byte_cnt;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_axis_tvalid && i_stat_rx_status) begin
                    if (full || frm_full) begin
                        if (s_axis_tlast) drop = 1'b1;
                        else              state_nxt = S_DISCARD;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        byte_nxt   = bytes_acc;
                        if (s_axis_tlast) begin
                            if (!s_axis_tuser && len_ok) begin
                                commit     = 1'b1;
                                wr_cmt_nxt = wr_ptr + PW'(1);
                            end else begin
                                drop       = 1'b1;
                                wr_ptr_nxt = wr_cmt;
                            end
                        end else if (bytes_acc > MAX_LEN) begin
                            wr_ptr_nxt = wr_cmt;
                            state_nxt  = S_DISCARD;
                        end else begin
                            state_nxt = S_RECV;
                        end
                    end
                end
            end
            S_RECV: begin
                if (!i_stat_rx_status) begin
                    wr_ptr_nxt = wr_cmt;
                    drop       = 1'b1;
                    state_nxt  = S_IDLE;
                end else if (s_axis_tvalid) begin
                    if (full) begin
                        wr_ptr_nxt = wr_cmt;
                        if (s_axis_tlast) begin
                            drop      = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_DISCARD;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        byte_nxt   = bytes_acc;
                        if (s_axis_tlast) begin
                            state_nxt = S_IDLE;
                            if (!s_axis_tuser && len_ok) begin
                                commit     = 1'b1;
                                wr_cmt_nxt = wr_ptr + PW'(1);
                            end else begin
                                drop       = 1'b1;
                                wr_ptr_nxt = wr_cmt;
                            end
                        end else if (bytes_acc > MAX_LEN) begin
                            wr_ptr_nxt = wr_cmt;
                            state_nxt  = S_DISCARD;
                        end
                    end
                end
            end
            S_DISCARD: begin
                // A link drop ends the discarded frame too, so it is counted exactly once
                if (!i_stat_rx_status || (s_axis_tvalid && s_axis_tlast)) begin
                    drop      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            byte_cnt   <= '0;
            o_good_cnt <= '0;
            o_drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            wr_cmt   <= wr_cmt_nxt;
            byte_cnt <= byte_nxt;
            if (commit) o_good_cnt <= o_good_cnt + 32'd1;
            if (drop)   o_drop_cnt <= o_drop_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
    end

    // Read side: RAM output register feeds the output register, one beat per cycle
    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign rd_en    = (o_frm_pending != '0) && (rd_ptr != wr_cmt) && (!rd_vld || out_free);
    assign pop      = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr        <= '0;
            rd_vld        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            o_frm_pending <= '0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            rd_vld <= rd_en || (rd_vld && !out_free);
            if (out_free) begin
                m_axis_tvalid <= rd_vld;
                if (rd_vld) begin
                    m_axis_tlast <= ram_q[72];
                    m_axis_tkeep <= ram_q[71:64];
                    m_axis_tdata <= ram_q[63:0];
                end
            end
            case ({commit, pop})
                2'b10:   o_frm_pending <= o_frm_pending + FW'(1);
                2'b01:   o_frm_pending <= o_frm_pending - FW'(1);
                default: o_frm_pending <= o_frm_pending;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb/tb_eth_rx_frame_filter.sv - scoreboard bench for eth_rx_frame_filter
module tb_eth_rx_frame_filter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stat = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic [31:0] good_cnt, drop_cnt;
    logic [6:0]  frm_pending;

    int checks = 0;
    int errors = 0;
    int exp_good = 0;
    int exp_drop = 0;
    int fid = 0;
    logic [72:0] sb_q[$];

    eth_rx_frame_filter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stat_rx_status(stat),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .o_good_cnt(good_cnt), .o_drop_cnt(drop_cnt), .o_frm_pending(frm_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (sb_q.size() == 0) check("spurious_beat", 73'(m_tvalid), 73'd0);
            else check("beat", {m_tlast, m_tkeep, m_tdata}, sb_q.pop_front());
        end
    end

    // drop_at >= 0 lowers link status from that beat index to the end of the frame
    task automatic send_frame(input int len, input bit err, input bit fits, input int drop_at);
        int nb = (len + 7) / 8;
        int rem = len % 8;
        bit pass = !err && len >= 64 && len <= 9600 && fits && drop_at < 0;
        logic [72:0] w;
        fid++;
        for (int i = 0; i < nb; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {8'(fid), 24'(i), 32'($urandom)};
            s_tlast  = (i == nb - 1);
            s_tkeep  = (s_tlast && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
            s_tuser  = s_tlast ? err : 1'b0;
            stat     = (drop_at < 0) || (i < drop_at);
            w = {s_tlast, s_tkeep, s_tdata};
            if (pass) sb_q.push_back(w);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; stat = 1'b1;
        if (pass) exp_good++; else exp_drop++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5000 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_drain"}, 73'(sb_q.size()), 73'd0);
        check({tag, "_pending"}, 73'(frm_pending), 73'd0);
        check({tag, "_good"}, 73'(good_cnt), 73'(exp_good));
        check({tag, "_drop"}, 73'(drop_cnt), 73'(exp_drop));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        exp_good = 0; exp_drop = 0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk); #1;
        check("rst_tvalid", 73'(m_tvalid), 73'd0);
        check("rst_out", {m_tlast, m_tkeep, m_tdata}, 73'd0);
        check("rst_cnts", {9'd0, good_cnt, drop_cnt}, 73'd0);
        check("rst_pending", 73'(frm_pending), 73'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single minimum frame, with latency measured from the sampling of tlast
        send_frame(64, 1'b0, 1'b1, -1);
        check("lat_e0", 73'(m_tvalid), 73'd0);
        @(posedge clk); #1;
        check("lat_e1", 73'(m_tvalid), 73'd0);
        @(posedge clk); #1;
        check("lat_e2", 73'(m_tvalid), 73'd1);
        drain("t1");

        do_reset();
        send_frame(128, 1'b1, 1'b1, -1);
        send_frame(72, 1'b0, 1'b1, -1);
        drain("t2");

        do_reset();
        send_frame(60, 1'b0, 1'b1, -1);
        send_frame(9608, 1'b0, 1'b1, -1);
        send_frame(64, 1'b0, 1'b1, -1);
        send_frame(65, 1'b0, 1'b1, -1);
        drain("t3");

        // 188-beat frames into a 512-beat buffer: two fit, the third overflows
        do_reset();
        m_tready = 1'b0;
        send_frame(1500, 1'b0, 1'b1, -1);
        send_frame(1500, 1'b0, 1'b1, -1);
        send_frame(1500, 1'b0, 1'b0, -1);
        repeat (4) @(posedge clk); #1;
        check("ovf_pending", 73'(frm_pending), 73'(exp_good));
        check("ovf_drop", 73'(drop_cnt), 73'(exp_drop));
        m_tready = 1'b1;
        drain("t4");
        send_frame(200, 1'b0, 1'b1, -1);
        drain("t4b");

        do_reset();
        send_frame(256, 1'b0, 1'b1, 5);
        repeat (2) @(posedge clk); #1;
        send_frame(256, 1'b0, 1'b1, -1);
        drain("t5");

        do_reset();
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) send_frame(64, 1'b0, 1'b1, -1);
        repeat (4) @(posedge clk); #1;
        check("mid_pending", 73'(frm_pending), 73'd3);
        m_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_tvalid", 73'(m_tvalid), 73'd0);
        check("mid_cnts", {9'd0, good_cnt, drop_cnt}, 73'd0);
        check("mid_pending0", 73'(frm_pending), 73'd0);
        sb_q.delete();
        exp_good = 0; exp_drop = 0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(100, 1'b0, 1'b1, -1);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
